// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - requester, memory and status signals of the instruction memory arbiter
interface imem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 19
);
    logic              boot_mode;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_address;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instruction;

    logic              load_req;
    logic              load_we;
    logic [ADDR_W-1:0] load_address;
    logic [DATA_W-1:0] load_wdata;
    logic              load_gnt;
    logic              load_rvalid;
    logic [DATA_W-1:0] load_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  boot_mode,
        input  fetch_req, fetch_address,
        output fetch_gnt, fetch_valid, fetch_instruction,
        input  load_req, load_we, load_address, load_wdata,
        output load_gnt, load_rvalid, load_rdata,
        output mem_en, mem_we, mem_address, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requester and memory side
    modport master (
        output boot_mode,
        output fetch_req, fetch_address,
        input  fetch_gnt, fetch_valid, fetch_instruction,
        output load_req, load_we, load_address, load_wdata,
        input  load_gnt, load_rvalid, load_rdata,
        input  mem_en, mem_we, mem_address, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter for the instruction memory port; IMEM_ARB_STATS_EN adds grant/stall counters
module imem_arbiter #(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 19,
    parameter int LOAD_BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    imem_arbiter_if.slave       bus
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]         fetch_grant_count,
    output logic [31:0]         load_grant_count,
    output logic [31:0]         fetch_stall_count
`endif
);
    localparam int CNT_W = $clog2(LOAD_BURST_MAX + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BOOT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_tag_fetch;
    logic              r_tag_load;
    logic [DATA_W-1:0] r_fetch_data;
    logic [DATA_W-1:0] r_load_data;

    logic              w_fetch_turn;
    logic              w_fetch_gnt;
    logic              w_load_gnt;
    logic              w_fetch_valid;
    logic              w_load_rvalid;

    // Fetch is owed its slot once the loader has used up its burst while fetch waited
    assign w_fetch_turn = bus.fetch_req && (r_burst_cnt >= CNT_W'(LOAD_BURST_MAX));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decision; all outputs are forced low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_gnt = 1'b0;
        w_load_gnt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.boot_mode) begin
                    w_state_nxt = ST_BOOT;
                end
                if (!reset) begin
                    if (bus.load_req && !w_fetch_turn) begin
                        w_load_gnt = 1'b1;
                    end else if (bus.fetch_req) begin
                        w_fetch_gnt = 1'b1;
                    end
                end
            end
            ST_BOOT: begin
                if (!bus.boot_mode) begin
                    w_state_nxt = ST_RUN;
                end
                if (!reset) begin
                    w_load_gnt = bus.load_req;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Loader burst counter: only meaningful in RUN, held untouched during BOOT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (!bus.fetch_req || w_fetch_gnt) begin
                r_burst_cnt <= '0;
            end else if (w_load_gnt && (r_burst_cnt < CNT_W'(LOAD_BURST_MAX))) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    // Owner tag: remembers who issued the read now in flight in the memory
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_fetch <= 1'b0;
            r_tag_load  <= 1'b0;
        end else begin
            r_tag_fetch <= w_fetch_gnt;
            r_tag_load  <= w_load_gnt && !bus.load_we;
        end
    end

    assign w_fetch_valid = r_tag_fetch && !reset;
    assign w_load_rvalid = r_tag_load && !reset;

    // Holding registers keep the last returned word visible while valid is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_data <= '0;
            r_load_data  <= '0;
        end else begin
            if (w_fetch_valid) begin
                r_fetch_data <= bus.mem_rdata;
            end
            if (w_load_rvalid) begin
                r_load_data <= bus.mem_rdata;
            end
        end
    end

    assign bus.fetch_gnt         = w_fetch_gnt;
    assign bus.load_gnt          = w_load_gnt;
    assign bus.fetch_valid       = w_fetch_valid;
    assign bus.load_rvalid       = w_load_rvalid;
    assign bus.fetch_instruction = w_fetch_valid ? bus.mem_rdata : r_fetch_data;
    assign bus.load_rdata        = w_load_rvalid ? bus.mem_rdata : r_load_data;

    assign bus.mem_en      = w_fetch_gnt || w_load_gnt;
    assign bus.mem_we      = w_load_gnt && bus.load_we;
    assign bus.mem_address = w_load_gnt  ? bus.load_address  :
                             w_fetch_gnt ? bus.fetch_address : '0;
    assign bus.mem_wdata   = w_load_gnt  ? bus.load_wdata    : '0;

    assign bus.busy = !reset && ((r_state == ST_BOOT) || w_load_gnt);

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] r_fetch_grant_count;
    logic [31:0] r_load_grant_count;
    logic [31:0] r_fetch_stall_count;

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_grant_count <= '0;
            r_load_grant_count  <= '0;
            r_fetch_stall_count <= '0;
        end else begin
            if (w_fetch_gnt && (r_fetch_grant_count != 32'hFFFF_FFFF)) begin
                r_fetch_grant_count <= r_fetch_grant_count + 32'd1;
            end
            if (w_load_gnt && (r_load_grant_count != 32'hFFFF_FFFF)) begin
                r_load_grant_count <= r_load_grant_count + 32'd1;
            end
            if (bus.fetch_req && !w_fetch_gnt && (r_fetch_stall_count != 32'hFFFF_FFFF)) begin
                r_fetch_stall_count <= r_fetch_stall_count + 32'd1;
            end
        end
    end

    assign fetch_grant_count = r_fetch_grant_count;
    assign load_grant_count  = r_load_grant_count;
    assign fetch_stall_count = r_fetch_stall_count;
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    imem_arbiter_if #(.ADDR_W(14), .DATA_W(19)) bus ();

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] fetch_grant_count;
    logic [31:0] load_grant_count;
    logic [31:0] fetch_stall_count;
`endif

    imem_arbiter #(.ADDR_W(14), .DATA_W(19), .LOAD_BURST_MAX(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus.slave)
`ifdef IMEM_ARB_STATS_EN
        ,
        .fetch_grant_count (fetch_grant_count),
        .load_grant_count  (load_grant_count),
        .fetch_stall_count (fetch_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory with one cycle read latency
    logic [18:0] mem [0:16383];
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_address];
        end
    end

    task automatic drive_idle;
        bus.boot_mode     = 1'b0;
        bus.fetch_req     = 1'b0;
        bus.fetch_address = '0;
        bus.load_req      = 1'b0;
        bus.load_we       = 1'b0;
        bus.load_address  = '0;
        bus.load_wdata    = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({bus.fetch_gnt, bus.fetch_valid, bus.load_gnt, bus.load_rvalid, bus.mem_en, bus.mem_we, bus.busy} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {bus.fetch_gnt, bus.fetch_valid, bus.load_gnt, bus.load_rvalid, bus.mem_en, bus.mem_we, bus.busy}); end
        checks++; if ({bus.mem_address, bus.mem_wdata} !== 33'h0) begin
            failures++; $display("FAIL reset_mem_bus got=%h exp=0", {bus.mem_address, bus.mem_wdata}); end
        checks++; if ({bus.fetch_instruction, bus.load_rdata} !== 38'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", {bus.fetch_instruction, bus.load_rdata}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_boot_load;
        bus.boot_mode = 1'b1;
        @(negedge clk);
        bus.fetch_req    = 1'b1;
        bus.fetch_address = 14'h0000;
        bus.load_req     = 1'b1;
        bus.load_we      = 1'b1;
        bus.load_address = 14'h0000;
        bus.load_wdata   = 19'h7FFFF;
        #1;
        checks++; if ({bus.fetch_gnt, bus.load_gnt, bus.mem_en, bus.mem_we, bus.busy} !== 5'b01111) begin
            failures++; $display("FAIL boot_wr0_ctrl got=%b exp=01111", {bus.fetch_gnt, bus.load_gnt, bus.mem_en, bus.mem_we, bus.busy}); end
        checks++; if ({bus.mem_address, bus.mem_wdata} !== {14'h0000, 19'h7FFFF}) begin
            failures++; $display("FAIL boot_wr0_bus got=%h/%h exp=0000/7ffff", bus.mem_address, bus.mem_wdata); end
        @(negedge clk);
        bus.load_address = 14'h3FFF;
        bus.load_wdata   = 19'h12345;
        #1;
        checks++; if ({bus.fetch_gnt, bus.load_gnt, bus.mem_en, bus.mem_we, bus.busy, bus.load_rvalid} !== 6'b011110) begin
            failures++; $display("FAIL boot_wr1_ctrl got=%b exp=011110", {bus.fetch_gnt, bus.load_gnt, bus.mem_en, bus.mem_we, bus.busy, bus.load_rvalid}); end
        checks++; if ({bus.mem_address, bus.mem_wdata} !== {14'h3FFF, 19'h12345}) begin
            failures++; $display("FAIL boot_wr1_bus got=%h/%h exp=3fff/12345", bus.mem_address, bus.mem_wdata); end
        @(negedge clk);
        bus.load_req = 1'b0;
        bus.load_we  = 1'b0;
        #1;
        checks++; if ({bus.fetch_gnt, bus.mem_en, bus.busy, bus.load_rvalid} !== 4'b0010) begin
            failures++; $display("FAIL boot_idle got=%b exp=0010", {bus.fetch_gnt, bus.mem_en, bus.busy, bus.load_rvalid}); end
        @(negedge clk);
        bus.boot_mode = 1'b0;
        bus.fetch_req = 1'b0;
        #1;
        checks++; if ({bus.fetch_gnt, bus.busy} !== 2'b01) begin
            failures++; $display("FAIL boot_exit got=%b exp=01", {bus.fetch_gnt, bus.busy}); end
    endtask

    task automatic test_fetch_stream;
        @(negedge clk);
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 14'h0000;
        #1;
        checks++; if ({bus.fetch_gnt, bus.mem_en, bus.mem_we, bus.busy, bus.mem_address} !== {4'b1100, 14'h0000}) begin
            failures++; $display("FAIL fetch_c1 got=%b/%h exp=1100/0000", {bus.fetch_gnt, bus.mem_en, bus.mem_we, bus.busy}, bus.mem_address); end
        @(negedge clk);
        bus.fetch_address = 14'h3FFF;
        #1;
        checks++; if ({bus.fetch_gnt, bus.fetch_valid, bus.mem_address} !== {2'b11, 14'h3FFF}) begin
            failures++; $display("FAIL fetch_c2_ctrl got=%b/%h exp=11/3fff", {bus.fetch_gnt, bus.fetch_valid}, bus.mem_address); end
        checks++; if (bus.fetch_instruction !== 19'h7FFFF) begin
            failures++; $display("FAIL fetch_c2_data got=%h exp=7ffff", bus.fetch_instruction); end
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++; if ({bus.fetch_valid, bus.fetch_instruction} !== {1'b1, 19'h12345}) begin
            failures++; $display("FAIL fetch_c3 got=%b/%h exp=1/12345", bus.fetch_valid, bus.fetch_instruction); end
        @(negedge clk);
        #1;
        checks++; if ({bus.fetch_valid, bus.fetch_instruction} !== {1'b0, 19'h12345}) begin
            failures++; $display("FAIL fetch_hold got=%b/%h exp=0/12345", bus.fetch_valid, bus.fetch_instruction); end
    endtask

    task automatic test_loader_write;
        @(negedge clk);
        bus.load_req     = 1'b1;
        bus.load_we      = 1'b1;
        bus.load_address = 14'h0100;
        bus.load_wdata   = 19'h2AAAA;
        #1;
        checks++; if ({bus.load_gnt, bus.mem_we, bus.busy, bus.mem_address, bus.mem_wdata} !== {3'b111, 14'h0100, 19'h2AAAA}) begin
            failures++; $display("FAIL lwr_grant got=%b/%h/%h exp=111/0100/2aaaa", {bus.load_gnt, bus.mem_we, bus.busy}, bus.mem_address, bus.mem_wdata); end
        @(negedge clk);
        bus.load_req      = 1'b0;
        bus.load_we       = 1'b0;
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 14'h0100;
        #1;
        checks++; if ({bus.load_rvalid, bus.fetch_gnt} !== 2'b01) begin
            failures++; $display("FAIL lwr_no_rvalid got=%b exp=01", {bus.load_rvalid, bus.fetch_gnt}); end
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++; if ({bus.fetch_valid, bus.fetch_instruction} !== {1'b1, 19'h2AAAA}) begin
            failures++; $display("FAIL lwr_readback got=%b/%h exp=1/2aaaa", bus.fetch_valid, bus.fetch_instruction); end
    endtask

    task automatic test_contention;
        logic [9:0] exp_load;
        exp_load = 10'b0111101111;   // bit i = loader wins cycle i
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 14'h3FFF;
        bus.load_req      = 1'b1;
        bus.load_we       = 1'b0;
        bus.load_address  = 14'h0000;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++; if ({bus.load_gnt, bus.fetch_gnt} !== {exp_load[i], !exp_load[i]}) begin
                failures++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, {bus.load_gnt, bus.fetch_gnt}, {exp_load[i], !exp_load[i]}); end
            if (i != 0) begin
                checks++; if ({bus.load_rvalid, bus.fetch_valid} !== {exp_load[i-1], !exp_load[i-1]}) begin
                    failures++; $display("FAIL cont_valid[%0d] got=%b exp=%b", i, {bus.load_rvalid, bus.fetch_valid}, {exp_load[i-1], !exp_load[i-1]}); end
                checks++; if ((exp_load[i-1] ? bus.load_rdata : bus.fetch_instruction) !== (exp_load[i-1] ? 19'h7FFFF : 19'h12345)) begin
                    failures++; $display("FAIL cont_data[%0d] got=%h/%h", i, bus.load_rdata, bus.fetch_instruction); end
            end
        end
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        #1;
        checks++; if ({bus.load_rvalid, bus.fetch_valid, bus.fetch_instruction} !== {2'b01, 19'h12345}) begin
            failures++; $display("FAIL cont_last got=%b/%h exp=01/12345", {bus.load_rvalid, bus.fetch_valid}, bus.fetch_instruction); end
`ifdef IMEM_ARB_STATS_EN
        checks++; if ({load_grant_count, fetch_grant_count, fetch_stall_count} !== {32'd8, 32'd2, 32'd8}) begin
            failures++; $display("FAIL stats got=%0d/%0d/%0d exp=8/2/8", load_grant_count, fetch_grant_count, fetch_stall_count); end
`endif
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        bus.fetch_req     = 1'b1;
        bus.fetch_address = 14'h3FFF;
        #1;
        checks++; if (bus.fetch_gnt !== 1'b1) begin
            failures++; $display("FAIL rmr_gnt got=%b exp=1", bus.fetch_gnt); end
        @(negedge clk);
        bus.fetch_req = 1'b0;
        reset         = 1'b1;
        #1;
        checks++; if (bus.fetch_valid !== 1'b0) begin
            failures++; $display("FAIL rmr_valid got=%b exp=0", bus.fetch_valid); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({bus.fetch_gnt, bus.fetch_valid, bus.load_gnt, bus.load_rvalid, bus.mem_en, bus.mem_we, bus.busy} !== 7'b0) begin
            failures++; $display("FAIL rmr_ctrl got=%b exp=0000000", {bus.fetch_gnt, bus.fetch_valid, bus.load_gnt, bus.load_rvalid, bus.mem_en, bus.mem_we, bus.busy}); end
        checks++; if ({bus.fetch_instruction, bus.load_rdata, bus.mem_address, bus.mem_wdata} !== 71'h0) begin
            failures++; $display("FAIL rmr_buses got=%h exp=0", {bus.fetch_instruction, bus.load_rdata, bus.mem_address, bus.mem_wdata}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_boot_load();
        test_fetch_stream();
        test_loader_write();
        test_contention();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
